// File: rtl/clock_reset_pkg.sv
// Shared types and constants for the clock_reset block: lock sequencer states,
// GPIO status bit layout and the sequencer counter sizing helper.
package clock_reset_pkg;

    typedef enum logic [2:0] {
        SWITCH,
        HOLD_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } lockseq_state_t;

    // Status field offsets inside one wizard's gpiops_i slice; the mclk wizard sits at GPIO_MCLK_BASE.
    localparam int unsigned GPIO_CLK_LOCKED_BIT   = 0;
    localparam int unsigned GPIO_LOCK_FAULT_BIT   = 1;
    localparam int unsigned GPIO_DOMAIN_RESET_BIT = 2;
    localparam int unsigned GPIO_RELOCK_COUNT_LSB = 8;
    localparam int unsigned GPIO_RELOCK_COUNT_W   = 8;
    localparam int unsigned GPIO_CLK_BASE         = 0;
    localparam int unsigned GPIO_MCLK_BASE        = 16;

    // Width of a counter that must reach (largest duration - 1).
    function automatic int lockseq_cnt_w(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/lockseq_sync.sv
// Async-reset multi-flop synchronizer for a single level signal crossing into clk.
module lockseq_sync #(
    parameter int SYNC_FF = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_FF-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_FF-2:0], d};
        end
    end

    assign q = sync_q[SYNC_FF-1];

endmodule

// File: rtl/clkwiz_lock_seq.sv
// pl_clk0-domain sequencer for one clocking wizard: source select, wizard reset,
// LOCKED qualification and the generated-domain reset request.
module clkwiz_lock_seq
    import clock_reset_pkg::*;
#(
    parameter int SYNC_FF       = 2,
    parameter int SWITCH_CYCLES = 8,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 1048576,
    parameter int LOCK_STABLE   = 256
) (
    input  logic       pl_clk0,
    input  logic       pl_reset_n,
    input  logic       clk_reset_req,
    input  logic       sys_reset,
    input  logic       clkin_src_sel,
    input  logic       clkwiz_locked_async,
    output logic       mux_sel,
    output logic       clkwiz_reset,
    output logic       clk_locked,
    output logic       domain_reset,
    output logic       lock_fault,
    output logic [7:0] relock_count
);

    localparam int CNT_W = lockseq_cnt_w(SWITCH_CYCLES, RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);

    // Each timed state starts the counter at 0 and leaves on the cycle it reads N-1.
    localparam logic [CNT_W-1:0] SWITCH_LAST  = CNT_W'(SWITCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);

    lockseq_state_t   state;
    lockseq_state_t   next_state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr;
    logic             req_q;
    logic             req_rise;
    logic             src_change;
    logic             locked_s;

    lockseq_sync #(
        .SYNC_FF (SYNC_FF)
    ) u_locked_sync (
        .clk   (pl_clk0),
        .rst_n (pl_reset_n),
        .d     (clkwiz_locked_async),
        .q     (locked_s)
    );

    assign req_rise   = clk_reset_req & ~req_q;
    assign src_change = clkin_src_sel != mux_sel;

    always_comb begin
        // NOTE: defaults first, so no branch of the case below can infer a latch.
        next_state = state;
        cnt_clr    = 1'b0;

        case (state)
            SWITCH: begin
                if (cnt == SWITCH_LAST) begin
                    next_state = HOLD_RST;
                    cnt_clr    = 1'b1;
                end
            end
            HOLD_RST: begin
                // A held request keeps restarting the minimum reset window.
                if (clk_reset_req) begin
                    cnt_clr = 1'b1;
                end else if (cnt == RST_LAST) begin
                    next_state = WAIT_LOCK;
                    cnt_clr    = 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    next_state = STABLE;
                    cnt_clr    = 1'b1;
                end else if (cnt == TIMEOUT_LAST) begin
                    next_state = FAULT;
                    cnt_clr    = 1'b1;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    next_state = WAIT_LOCK;
                    cnt_clr    = 1'b1;
                end else if (cnt == STABLE_LAST) begin
                    next_state = RUN;
                    cnt_clr    = 1'b1;
                end
            end
            RUN: begin
                cnt_clr = 1'b1;
                if (!locked_s) next_state = HOLD_RST;
            end
            FAULT: begin
                cnt_clr = 1'b1;
            end
            default: begin
                next_state = HOLD_RST;
                cnt_clr    = 1'b1;
            end
        endcase

        // Restart events override whatever the current state decided.
        if (src_change) begin
            next_state = SWITCH;
            cnt_clr    = 1'b1;
        end else if (req_rise) begin
            next_state = HOLD_RST;
            cnt_clr    = 1'b1;
        end
    end

    always_ff @(posedge pl_clk0 or negedge pl_reset_n) begin
        if (!pl_reset_n) begin
            state        <= HOLD_RST;
            cnt          <= '0;
            req_q        <= 1'b0;
            mux_sel      <= 1'b0;
            clkwiz_reset <= 1'b1;
            clk_locked   <= 1'b0;
            domain_reset <= 1'b1;
            lock_fault   <= 1'b0;
            relock_count <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every register samples pre-edge values.
            state        <= next_state;
            cnt          <= cnt_clr ? '0 : cnt + CNT_W'(1);
            req_q        <= clk_reset_req;
            // mux_sel only moves on SWITCH entry, so the BUFGMUX select never glitches.
            if (src_change) mux_sel <= clkin_src_sel;
            // Outputs are decoded from next_state so they change together with the state.
            clkwiz_reset <= next_state inside {SWITCH, HOLD_RST, FAULT};
            clk_locked   <= next_state == RUN;
            domain_reset <= sys_reset | (next_state != RUN);
            lock_fault   <= next_state == FAULT;
            if (state == RUN && !locked_s && relock_count != 8'hFF) begin
                relock_count <= relock_count + 8'd1;
            end
        end
    end

endmodule
